// File: rtl/delayfixed_fall.sv
// Asymmetric level delay: rising edges of i pass after synchronization only,
// falling edges are held off for DELAY_CYC cycles so short low glitches vanish.
module delayfixed_fall #(
    parameter int DELAY_CYC = 10,
    parameter int CNT_W     = 8
) (
    input  logic CELCLK,
    input  logic CELRSTB,
    input  logic CELV,
    input  logic CELG,
    input  logic CELSUB,
    input  logic i,
    output logic o,
    output logic busy,
    output logic fall_done
);

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_HIGH     = 2'd1,
        ST_FALLWAIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // The counter must be able to hold DELAY_CYC-1 and a zero delay is meaningless.
    generate
        if (DELAY_CYC < 1 || DELAY_CYC > (2 ** CNT_W) - 1) begin : g_bad_delay
            $error("delayfixed_fall: DELAY_CYC out of range 1..2^CNT_W-1");
        end
    endgenerate

    // Supply/ground/substrate pins exist for the netlist only.
    logic w_unused;
    assign w_unused = &{1'b0, CELV, CELG, CELSUB};

    logic             r_s1;
    logic             r_s2;
    state_t           r_state;
    state_t           w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             r_o;
    logic             w_oNext;
    logic             r_busy;
    logic             w_busyNext;
    logic             r_fallDone;
    logic             w_fallDoneNext;

    always_ff @(posedge CELCLK or negedge CELRSTB) begin
        if (!CELRSTB) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i;
            r_s2 <= r_s1;
        end
    end

    // Outputs are computed alongside the next state so they come straight from flops.
    always_comb begin
        w_stateNext    = r_state;
        w_cntNext      = r_cnt;
        w_oNext        = r_o;
        w_busyNext     = r_busy;
        w_fallDoneNext = 1'b0;
        case (r_state)
            ST_LOW: begin
                w_oNext    = 1'b0;
                w_busyNext = 1'b0;
                if (r_s2) begin
                    w_stateNext = ST_HIGH;
                    w_oNext     = 1'b1;
                end
            end
            ST_HIGH: begin
                w_oNext    = 1'b1;
                w_busyNext = 1'b0;
                if (!r_s2) begin
                    w_stateNext = ST_FALLWAIT;
                    w_cntNext   = LOAD_VAL;
                    w_busyNext  = 1'b1;
                end
            end
            ST_FALLWAIT: begin
                w_oNext = 1'b1;
                // A returning high wins over an expiring count, so o never drops.
                if (r_s2) begin
                    w_stateNext = ST_HIGH;
                    w_cntNext   = '0;
                    w_busyNext  = 1'b0;
                end else if (r_cnt == '0) begin
                    w_stateNext    = ST_LOW;
                    w_oNext        = 1'b0;
                    w_busyNext     = 1'b0;
                    w_fallDoneNext = 1'b1;
                end else begin
                    w_cntNext  = r_cnt - CNT_ONE;
                    w_busyNext = 1'b1;
                end
            end
            default: begin
                w_stateNext = ST_LOW;
                w_cntNext   = '0;
                w_oNext     = 1'b0;
                w_busyNext  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CELCLK or negedge CELRSTB) begin
        if (!CELRSTB) begin
            r_state    <= ST_LOW;
            r_cnt      <= '0;
            r_o        <= 1'b0;
            r_busy     <= 1'b0;
            r_fallDone <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_cnt      <= w_cntNext;
            r_o        <= w_oNext;
            r_busy     <= w_busyNext;
            r_fallDone <= w_fallDoneNext;
        end
    end

    assign o         = r_o;
    assign busy      = r_busy;
    assign fall_done = r_fallDone;

endmodule

// File: tb/tb_delayfixed_fall.sv
// Directed bench for delayfixed_fall: three instances (delay 10, 1 and 255)
// driven from one clock and reset, each with its own input level.
module tb_delayfixed_fall;

    logic clk = 1'b0;
    logic rstN;
    logic i10, i1, i255;
    logic o10, busy10, fd10;
    logic o1, busy1, fd1;
    logic o255, busy255, fd255;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    delayfixed_fall #(.DELAY_CYC(10), .CNT_W(8)) u10 (
        .CELCLK(clk), .CELRSTB(rstN), .CELV(1'b1), .CELG(1'b0), .CELSUB(1'b0),
        .i(i10), .o(o10), .busy(busy10), .fall_done(fd10)
    );

    delayfixed_fall #(.DELAY_CYC(1), .CNT_W(8)) u1 (
        .CELCLK(clk), .CELRSTB(rstN), .CELV(1'b1), .CELG(1'b0), .CELSUB(1'b0),
        .i(i1), .o(o1), .busy(busy1), .fall_done(fd1)
    );

    delayfixed_fall #(.DELAY_CYC(255), .CNT_W(8)) u255 (
        .CELCLK(clk), .CELRSTB(rstN), .CELV(1'b1), .CELG(1'b0), .CELSUB(1'b0),
        .i(i255), .o(o255), .busy(busy255), .fall_done(fd255)
    );

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    // Advance n rising edges and land just after the last one.
    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rstN = 1'b0;
        i10  = 1'b0;
        i1   = 1'b0;
        i255 = 1'b0;
        waitCycles(3);
        checkOutput("rst_o", o10, 1'b0);
        checkOutput("rst_busy", busy10, 1'b0);
        checkOutput("rst_fd", fd10, 1'b0);
        rstN = 1'b1;

        // Basic rise/fall with DELAY_CYC=10, edge 0 is now.
        i10 = 1'b1;
        waitCycles(2);
        checkOutput("rise_e2_o", o10, 1'b0);
        waitCycles(1);
        checkOutput("rise_e3_o", o10, 1'b1);
        waitCycles(17);
        i10 = 1'b0;
        waitCycles(2);
        checkOutput("fall_e22_busy", busy10, 1'b0);
        for (int k = 23; k <= 32; k++) begin
            waitCycles(1);
            checkOutput($sformatf("fall_e%0d_o", k), o10, 1'b1);
            checkOutput($sformatf("fall_e%0d_busy", k), busy10, 1'b1);
            checkOutput($sformatf("fall_e%0d_fd", k), fd10, 1'b0);
        end
        waitCycles(1);
        checkOutput("fall_e33_o", o10, 1'b0);
        checkOutput("fall_e33_busy", busy10, 1'b0);
        checkOutput("fall_e33_fd", fd10, 1'b1);
        waitCycles(1);
        checkOutput("fall_e34_fd", fd10, 1'b0);

        // Glitch absorb: five-cycle low on i while o is high.
        i10 = 1'b1;
        waitCycles(6);
        checkOutput("glitch_pre_o", o10, 1'b1);
        i10 = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            if (k == 6) i10 = 1'b1;
            waitCycles(1);
            if (k == 5) i10 = 1'b1;
            checkOutput($sformatf("glitch_%0d_o", k), o10, 1'b1);
            checkOutput($sformatf("glitch_%0d_fd", k), fd10, 1'b0);
            checkOutput($sformatf("glitch_%0d_busy", k), busy10, (k >= 3 && k <= 7));
        end

        // DELAY_CYC=1: plain fall is four edges.
        i1 = 1'b1;
        waitCycles(5);
        checkOutput("d1_pre_o", o1, 1'b1);
        i1 = 1'b0;
        waitCycles(3);
        checkOutput("d1_e3_o", o1, 1'b1);
        checkOutput("d1_e3_busy", busy1, 1'b1);
        waitCycles(1);
        checkOutput("d1_e4_o", o1, 1'b0);
        checkOutput("d1_e4_fd", fd1, 1'b1);

        // DELAY_CYC=1: one-cycle low on s2, rise coincides with cnt==0.
        i1 = 1'b1;
        waitCycles(5);
        checkOutput("d1_glitch_pre_o", o1, 1'b1);
        i1 = 1'b0;
        waitCycles(1);
        i1 = 1'b1;
        for (int k = 2; k <= 8; k++) begin
            waitCycles(1);
            checkOutput($sformatf("d1_glitch_%0d_o", k), o1, 1'b1);
            checkOutput($sformatf("d1_glitch_%0d_fd", k), fd1, 1'b0);
            checkOutput($sformatf("d1_glitch_%0d_busy", k), busy1, (k == 3));
        end

        // Reset asserted mid-FALLWAIT with cnt=4 on the delay-10 instance.
        i10 = 1'b0;
        waitCycles(8);
        checkOutput("midrst_pre_o", o10, 1'b1);
        checkOutput("midrst_pre_busy", busy10, 1'b1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("midrst_o", o10, 1'b0);
        checkOutput("midrst_busy", busy10, 1'b0);
        checkOutput("midrst_fd", fd10, 1'b0);
        i10 = 1'b1;
        waitCycles(2);
        rstN = 1'b1;
        waitCycles(2);
        checkOutput("rel_e2_o", o10, 1'b0);
        waitCycles(1);
        checkOutput("rel_e3_o", o10, 1'b1);
        checkOutput("rel_e3_fd", fd10, 1'b0);
        checkOutput("rel_e3_d1_o", o1, 1'b1);

        // Short high pulse: two synchronized high cycles stretch to twelve.
        i10 = 1'b0;
        waitCycles(20);
        checkOutput("pulse_pre_o", o10, 1'b0);
        i10 = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            waitCycles(1);
            if (k == 2) i10 = 1'b0;
            checkOutput($sformatf("pulse_%0d_o", k), o10, (k >= 3 && k <= 14));
            checkOutput($sformatf("pulse_%0d_fd", k), fd10, (k == 15));
        end

        // Largest legal delay: fall latency is 258 edges.
        i255 = 1'b1;
        waitCycles(5);
        checkOutput("d255_pre_o", o255, 1'b1);
        i255 = 1'b0;
        waitCycles(257);
        checkOutput("d255_e257_o", o255, 1'b1);
        checkOutput("d255_e257_busy", busy255, 1'b1);
        waitCycles(1);
        checkOutput("d255_e258_o", o255, 1'b0);
        checkOutput("d255_e258_fd", fd255, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
